// File: rtl/scan_index_gen.sv
// scan_index_gen: 3-bit scan index for a downstream 3-to-8 one-hot decoder.
// A prescaler of DIV enabled cycles paces each step. The index moves up or
// down with wraparound (MODE=0) or bounces between 0 and 7 (MODE=1).
//
// Output strobe: TICK is a one-cycle valid pulse that is high in exactly the
// cycle a new stepped index first appears on {A,B,C}. There is no ready; the
// consumer must sample {A,B,C} while TICK is high. A LOAD changes the index
// without raising TICK.
module scan_index_gen #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       DIR,
  input  logic       MODE,
  input  logic       LOAD,
  input  logic [2:0] D,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       TICK
);

  // The prescaler needs at least one bit even when DIV is 1.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          pdir;
  logic          tick_q;

  logic [2:0]    nxt_idx;
  logic          nxt_pdir;
  logic          step;

  // A step fires only on an enabled cycle whose prescaler count is terminal.
  assign step = EN && (cnt == LAST);

  // Next index and ping-pong direction assuming this cycle is a step.
  always_comb begin
    nxt_idx  = idx;
    nxt_pdir = pdir;
    if (!MODE) begin
      // Wrap mode follows DIR directly; pdir tracks DIR so that entering
      // ping-pong continues in the current direction.
      nxt_pdir = DIR;
      nxt_idx  = DIR ? (idx - 3'd1) : (idx + 3'd1);
    end else if (!pdir) begin
      if (idx == 3'd7) begin
        nxt_idx  = 3'd6;
        nxt_pdir = 1'b1;
      end else begin
        nxt_idx = idx + 3'd1;
      end
    end else begin
      if (idx == 3'd0) begin
        nxt_idx  = 3'd1;
        nxt_pdir = 1'b0;
      end else begin
        nxt_idx = idx - 3'd1;
      end
    end
  end

  // State update with priority reset > load > step > count > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 3'd0;
      cnt    <= '0;
      pdir   <= 1'b0;
      tick_q <= 1'b0;
    end else if (LOAD) begin
      idx    <= D;
      cnt    <= '0;
      pdir   <= DIR;
      tick_q <= 1'b0;
    end else if (step) begin
      idx    <= nxt_idx;
      cnt    <= '0;
      pdir   <= nxt_pdir;
      tick_q <= 1'b1;
    end else if (EN) begin
      cnt    <= cnt + 1'b1;
      tick_q <= 1'b0;
      if (!MODE) begin
        pdir <= DIR;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign {A, B, C} = idx;
  assign TICK      = tick_q;

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed bench for scan_index_gen. Two instances: u_div4 (DIV=4) covers
// wrap, load, freeze and collision cases; u_div1 (DIV=1) covers ping-pong
// with a continuous TICK. Expected {cycle, index} pairs are queued by the
// driver and consumed by per-instance monitors whenever TICK is seen.
module tb_scan_index_gen;

  localparam int W = 19;  // {cycle[15:0], idx[2:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       rst_a, en_a, dir_a, mode_a, load_a;
  logic [2:0] d_a;
  logic       a_a, b_a, c_a, tick_a;

  logic       rst_b, en_b, dir_b, mode_b, load_b;
  logic [2:0] d_b;
  logic       a_b, b_b, c_b, tick_b;

  scan_index_gen #(.DIV(4)) u_div4 (
    .clk(clk), .rst(rst_a), .EN(en_a), .DIR(dir_a), .MODE(mode_a),
    .LOAD(load_a), .D(d_a), .A(a_a), .B(b_a), .C(c_a), .TICK(tick_a)
  );

  scan_index_gen #(.DIV(1)) u_div1 (
    .clk(clk), .rst(rst_b), .EN(en_b), .DIR(dir_b), .MODE(mode_b),
    .LOAD(load_b), .D(d_b), .A(a_b), .B(b_b), .C(c_b), .TICK(tick_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input int idx, input int at);
    exp_a_q.push_back({at[15:0], idx[2:0]});
  endtask

  task automatic push_b(input int idx, input int at);
    exp_b_q.push_back({at[15:0], idx[2:0]});
  endtask

  // Monitor for the DIV=4 instance.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (tick_a === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        check("div4_unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        check("div4_tick_idx", {29'd0, a_a, b_a, c_a}, {29'd0, e[2:0]});
        check("div4_tick_cycle", cyc & 32'hffff, {16'd0, e[W-1:3]});
      end
    end
  end

  // Monitor for the DIV=1 instance.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (tick_b === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        check("div1_unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        check("div1_tick_idx", {29'd0, a_b, b_b, c_b}, {29'd0, e[2:0]});
        check("div1_tick_cycle", cyc & 32'hffff, {16'd0, e[W-1:3]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t;
    int t2;
    int tb;
    logic [2:0] pp_seq [16];

    rst_a = 1'b1; en_a = 1'b0; dir_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; d_a = 3'd0;
    rst_b = 1'b1; en_b = 1'b0; dir_b = 1'b0; mode_b = 1'b1; load_b = 1'b0; d_b = 3'd0;

    // Reset for two cycles.
    wait_n(2);
    check("rst_idx_a", {29'd0, a_a, b_a, c_a}, 32'd0);
    check("rst_tick_a", {31'd0, tick_a}, 32'd0);
    check("rst_idx_b", {29'd0, a_b, b_b, c_b}, 32'd0);
    check("rst_tick_b", {31'd0, tick_b}, 32'd0);

    // Wrap up: 1..7,0, one step every 4 cycles.
    rst_a = 1'b0; en_a = 1'b1;
    t = cyc;
    for (int k = 1; k <= 8; k++) push_a(k % 8, t + 4 * k);
    wait_n(32);

    // Wrap down from a loaded 1: 0,7,6, first change 4 cycles after load.
    load_a = 1'b1; d_a = 3'd1; dir_a = 1'b1;
    t = cyc + 1;
    push_a(0, t + 4); push_a(7, t + 8); push_a(6, t + 12);
    wait_n(1);
    load_a = 1'b0;
    check("load_idx", {29'd0, a_a, b_a, c_a}, 32'd1);
    check("load_tick", {31'd0, tick_a}, 32'd0);
    wait_n(12);

    // Freeze with cnt==2 for five cycles; step lands two enabled cycles later.
    wait_n(2);
    en_a = 1'b0;
    push_a(5, t + 21);
    for (int i = 0; i < 5; i++) begin
      wait_n(1);
      check("freeze_idx", {29'd0, a_a, b_a, c_a}, 32'd6);
      check("freeze_tick", {31'd0, tick_a}, 32'd0);
    end
    en_a = 1'b1;
    wait_n(5);

    // LOAD on the step edge: load wins, no TICK, prescaler restarts.
    load_a = 1'b1; d_a = 3'd5;
    push_a(4, t + 29);
    wait_n(1);
    load_a = 1'b0;
    check("collide_load_idx", {29'd0, a_a, b_a, c_a}, 32'd5);
    check("collide_load_tick", {31'd0, tick_a}, 32'd0);
    wait_n(4);

    // Reset together with LOAD: reset wins.
    rst_a = 1'b1; load_a = 1'b1; d_a = 3'd6;
    wait_n(1);
    check("collide_rst_idx", {29'd0, a_a, b_a, c_a}, 32'd0);
    check("collide_rst_tick", {31'd0, tick_a}, 32'd0);

    // Mode switch: load 2 with DIR=0, run wrap mode with DIR=1 for one
    // enabled cycle, then ping-pong must continue downward: 1,0,1,2.
    rst_a = 1'b0; load_a = 1'b1; d_a = 3'd2; dir_a = 1'b0; mode_a = 1'b0;
    wait_n(1);
    check("mode_load_idx", {29'd0, a_a, b_a, c_a}, 32'd2);
    load_a = 1'b0; dir_a = 1'b1;
    t2 = cyc;
    wait_n(1);
    mode_a = 1'b1; dir_a = 1'b0;
    push_a(1, t2 + 4); push_a(0, t2 + 8); push_a(1, t2 + 12); push_a(2, t2 + 16);
    wait_n(15);
    en_a = 1'b0;

    // Ping-pong at DIV=1: TICK every enabled cycle, DIR toggles ignored.
    pp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
               3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    tb = cyc;
    rst_b = 1'b0; en_b = 1'b1;
    for (int i = 0; i < 16; i++) push_b(pp_seq[i], tb + 1 + i);
    for (int i = 0; i < 16; i++) begin
      wait_n(1);
      if (i == 3 || i == 9) dir_b = ~dir_b;
    end
    en_b = 1'b0;
    wait_n(1);
    check("div1_hold_tick", {31'd0, tick_b}, 32'd0);
    check("div1_hold_idx", {29'd0, a_b, b_b, c_b}, 32'd2);

    // Every queued step must have been observed.
    wait_n(3);
    check("div4_pending", exp_a_q.size(), 32'd0);
    check("div1_pending", exp_b_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
